// File: rtl/sram_mem_controller.sv
// sram_mem_controller: MEM-stage data memory front end for an external 16-bit
// asynchronous SRAM. Each 32-bit load/store becomes two half-word accesses
// (low half, then high half), and each is held for WAIT_CYCLES cycles. ready
// stalls the pipeline while a request is in flight.
// Optional build macro: SRAM_READ_BYPASS_EN adds a one-entry last-read buffer
// that completes repeat reads of the same word without touching the SRAM.
module sram_mem_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we_n,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              is_wr_q, is_wr_n;
  logic [31:0]       word_q, word_n;
  logic [31:0]       wdata_q, wdata_n;
  logic [31:0]       req_word;

  logic [SRAM_ADDR_W-1:0] addr_n;
  logic                   we_n_n;
  logic [15:0]            dq_out_n;
  logic                   dq_oe_n;

`ifdef SRAM_READ_BYPASS_EN
  logic        byp_valid;
  logic [31:0] byp_tag;
  logic        byp_hit;
`endif

  // Half-word SRAM address for a word; out-of-range words wrap by truncation.
  function automatic logic [SRAM_ADDR_W-1:0] half_addr(input logic [31:0] w,
                                                        input logic      hi);
    return SRAM_ADDR_W'({w, hi});
  endfunction

  assign req_word = (address - 32'(BASE_ADDR)) >> 2;

  // Pipeline stall: low while a request is pending and not yet completing.
  assign ready = ~(wr_en | rd_en) | (state == DONE);

`ifdef SRAM_READ_BYPASS_EN
  assign byp_hit = rd_en & ~wr_en & byp_valid & (byp_tag == req_word);
`endif

  // Next-state logic: request capture in IDLE and per-half wait counting.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    is_wr_n = is_wr_q;
    word_n  = word_q;
    wdata_n = wdata_q;
    unique case (state)
      IDLE: begin
        if (wr_en | rd_en) begin
          is_wr_n = wr_en;
          word_n  = req_word;
          wdata_n = write_data;
          cnt_n   = '0;
          state_n = LOW;
`ifdef SRAM_READ_BYPASS_EN
          if (byp_hit) state_n = DONE;
`endif
        end
      end
      LOW: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = HIGH;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HIGH: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // SRAM pin values for the upcoming cycle. They are derived from the next state
  // so the pins leave flops cleanly. The address and data are held outside an
  // access, so the bus does not toggle when it is not in use.
  always_comb begin
    addr_n   = sram_addr;
    dq_out_n = sram_dq_out;
    dq_oe_n  = 1'b0;
    we_n_n   = 1'b1;
    unique case (state_n)
      LOW: begin
        addr_n = half_addr(word_n, 1'b0);
        if (is_wr_n) begin
          dq_oe_n  = 1'b1;
          dq_out_n = wdata_n[15:0];
          we_n_n   = (cnt_n == CNT_LAST);
        end
      end
      HIGH: begin
        addr_n = half_addr(word_n, 1'b1);
        if (is_wr_n) begin
          dq_oe_n  = 1'b1;
          dq_out_n = wdata_n[31:16];
          we_n_n   = (cnt_n == CNT_LAST);
        end
      end
      default: ;
    endcase
  end

  // FSM state, wait counter and latched request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      is_wr_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      is_wr_q <= is_wr_n;
      word_q  <= word_n;
      wdata_q <= wdata_n;
    end
  end

  // Registered SRAM control/data pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr   <= '0;
      sram_we_n   <= 1'b1;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
    end else begin
      sram_addr   <= addr_n;
      sram_we_n   <= we_n_n;
      sram_dq_out <= dq_out_n;
      sram_dq_oe  <= dq_oe_n;
    end
  end

  // Read capture: sample SRAM data on the last cycle of each half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= '0;
    end else if (!is_wr_q && cnt == CNT_LAST) begin
      if (state == LOW)  read_data[15:0]  <= sram_dq_in;
      if (state == HIGH) read_data[31:16] <= sram_dq_in;
    end
  end

`ifdef SRAM_READ_BYPASS_EN
  // Last-read buffer tag. read_data only changes on reads, so it doubles as
  // the buffered data word, and a hit simply leaves it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_valid <= 1'b0;
      byp_tag   <= '0;
    end else if (state == IDLE && wr_en) begin
      byp_valid <= 1'b0;
    end else if (state == DONE && !is_wr_q) begin
      byp_valid <= 1'b1;
      byp_tag   <= word_q;
    end
  end
`endif

endmodule

// File: tb/tb_sram_mem_controller.sv
// tb_sram_mem_controller: directed self-checking bench for sram_mem_controller
// with a behavioural 64-entry half-word SRAM model. Default parameters are used.
// Build with SRAM_READ_BYPASS_EN defined to also exercise the read buffer.
module tb_sram_mem_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;

  logic [15:0] mem [0:63];

  int checks = 0;
  int failures = 0;

  int          lat;
  int          st_we_lo;
  int          st_oe_hi;
  logic [17:0] st_a1;
  logic [17:0] st_a3;
  logic        st_moved;
  logic [17:0] st_a0;

  sram_mem_controller #(
    .BASE_ADDR  (1024),
    .WAIT_CYCLES(2),
    .SRAM_ADDR_W(18)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_we_n  (sram_we_n),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in)
  );

  always #5 clk = ~clk;

  // SRAM model: asynchronous read, write while we_n is low.
  assign sram_dq_in = mem[sram_addr[5:0]];
  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) mem[sram_addr[5:0]] <= sram_dq_out;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Sample each cycle on the falling edge until ready, collecting bus activity.
  task automatic wait_rdy();
    lat = -1;
    st_we_lo = 0;
    st_oe_hi = 0;
    st_moved = 1'b0;
    st_a0 = sram_addr;
    st_a1 = sram_addr;
    st_a3 = sram_addr;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!sram_we_n) st_we_lo++;
      if (sram_dq_oe) st_oe_hi++;
      if (sram_addr != st_a0) st_moved = 1'b1;
      if (c == 1) st_a1 = sram_addr;
      if (c == 3) st_a3 = sram_addr;
      if (ready) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic do_req(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    wr_en = wr;
    rd_en = rd;
    address = a;
    write_data = d;
    wait_rdy();
    @(posedge clk); #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_rdata", read_data, 32'h0);
    check("rst_addr", 32'(sram_addr), 32'h0);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_dq_out", 32'(sram_dq_out), 32'h0);

    // Write 0x12345678 to 1024 -> halves 0 and 1.
    do_req(1'b1, 1'b0, 32'd1024, 32'h12345678);
    check("wr1_lat", lat, 32'd5);
    check("wr1_we_lo", st_we_lo, 32'd2);
    check("wr1_oe_hi", st_oe_hi, 32'd4);
    check("wr1_a_lo", 32'(st_a1), 32'd0);
    check("wr1_a_hi", 32'(st_a3), 32'd1);
    check("wr1_mem0", 32'(mem[0]), 32'h5678);
    check("wr1_mem1", 32'(mem[1]), 32'h1234);
    @(negedge clk);
    check("wr1_idle_ready", 32'(ready), 32'd1);

    // Read it back.
    do_req(1'b0, 1'b1, 32'd1024, 32'h0);
    check("rd1_lat", lat, 32'd5);
    check("rd1_data", read_data, 32'h12345678);
    check("rd1_oe", st_oe_hi, 32'd0);
    check("rd1_we_lo", st_we_lo, 32'd0);

    // Write 0xDEADBEEF to 1032 -> halves 4 and 5, then read.
    do_req(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF);
    check("wr2_lat", lat, 32'd5);
    check("wr2_a_lo", 32'(st_a1), 32'd4);
    check("wr2_a_hi", 32'(st_a3), 32'd5);
    check("wr2_mem4", 32'(mem[4]), 32'hBEEF);
    check("wr2_mem5", 32'(mem[5]), 32'hDEAD);
    do_req(1'b0, 1'b1, 32'd1032, 32'h0);
    check("rd2_lat", lat, 32'd5);
    check("rd2_data", read_data, 32'hDEADBEEF);

    // wr_en and rd_en both high: treated as a write.
    do_req(1'b1, 1'b1, 32'd1028, 32'hA5A5A5A5);
    check("both_lat", lat, 32'd5);
    check("both_mem2", 32'(mem[2]), 32'hA5A5);
    check("both_mem3", 32'(mem[3]), 32'hA5A5);
    check("both_oe_hi", st_oe_hi, 32'd4);
    check("both_rdata", read_data, 32'hDEADBEEF);

    // Back-to-back reads: second request present the cycle after DONE.
    @(posedge clk); #1;
    rd_en = 1'b1;
    address = 32'd1024;
    wait_rdy();
    check("b2b_lat1", lat, 32'd5);
    check("b2b_data1", read_data, 32'h12345678);
    @(posedge clk); #1;
    address = 32'd1032;
    wait_rdy();
    check("b2b_lat2", lat, 32'd5);
    check("b2b_data2", read_data, 32'hDEADBEEF);
    @(posedge clk); #1;
    rd_en = 1'b0;

    // Request dropped mid-transaction still completes.
    @(posedge clk); #1;
    wr_en = 1'b1;
    address = 32'd1036;
    write_data = 32'h0BADF00D;
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    check("drop_ready", 32'(ready), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("drop_mem6", 32'(mem[6]), 32'hF00D);
    check("drop_mem7", 32'(mem[7]), 32'h0BAD);
    check("drop_we_n", 32'(sram_we_n), 32'd1);

    // Asynchronous reset in cycle 2 of a write.
    @(posedge clk); #1;
    wr_en = 1'b1;
    address = 32'd1040;
    write_data = 32'h11112222;
    @(posedge clk);
    @(posedge clk); #1;
    check("rstw_oe_before", 32'(sram_dq_oe), 32'd1);
    rst = 1'b1;
    #1;
    check("rstw_we_n", 32'(sram_we_n), 32'd1);
    check("rstw_oe", 32'(sram_dq_oe), 32'd0);
    check("rstw_rdata", read_data, 32'h0);
    check("rstw_addr", 32'(sram_addr), 32'h0);
    check("rstw_ready_req", 32'(ready), 32'd0);
    wr_en = 1'b0;
    #1;
    check("rstw_ready_idle", 32'(ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Operation resumes after reset.
    do_req(1'b0, 1'b1, 32'd1024, 32'h0);
    check("post_rst_lat", lat, 32'd5);
    check("post_rst_data", read_data, 32'h12345678);

`ifdef SRAM_READ_BYPASS_EN
    // Repeat read of the same word is served from the buffer.
    do_req(1'b0, 1'b1, 32'd1024, 32'h0);
    check("byp_lat", lat, 32'd1);
    check("byp_moved", 32'(st_moved), 32'd0);
    check("byp_oe", st_oe_hi, 32'd0);
    check("byp_data", read_data, 32'h12345678);
    // A write invalidates the buffer.
    do_req(1'b1, 1'b0, 32'd1024, 32'h55AA33CC);
    check("byp_wr_lat", lat, 32'd5);
    do_req(1'b0, 1'b1, 32'd1024, 32'h0);
    check("byp_miss_lat", lat, 32'd5);
    check("byp_miss_data", read_data, 32'h55AA33CC);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
Replaces the on-chip data memory behind the MEM stage with an external 16-bit asynchronous SRAM. The controller takes one 32-bit load/store request from the MEM stage and splits it into two 16-bit SRAM accesses, each held for a fixed number of wait cycles. It drives ready low while a request is in progress so the hazard/freeze logic stalls the pipeline.

Parameters:
BASE_ADDR, 1024, byte address that maps to SRAM word 0; subtracted from the incoming address.
WAIT_CYCLES, 2, cycles each 16-bit half-access is held (≥1).
SRAM_ADDR_W, 18, width of the SRAM half-word address bus.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
wr_en  in  1  store request from MEM stage (level, held while frozen)
rd_en  in  1  load request from MEM stage (level, held while frozen)
address  in  32  byte address (ALU result)
write_data  in  32  store data (Rm value)
read_data  out  32  load result
ready  out  1  1 = no request pending or request completing this cycle
sram_addr  out  SRAM_ADDR_W  SRAM half-word address
sram_we_n  out  1  SRAM write enable, active low
sram_dq_out  out  16  data driven to SRAM
sram_dq_oe  out  1  1 = controller drives the SRAM data bus
sram_dq_in  in  16  data returned by SRAM

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk.
- Reset: state=IDLE, read_data=0, sram_addr=0, sram_we_n=1, sram_dq_oe=0, sram_dq_out=0, wait counter=0.
- Reset asserted mid-transaction aborts it immediately. The SRAM write may be partial; no recovery is attempted.
- Address mapping: word = (address - BASE_ADDR) >> 2. Low half = {word, 0}, high half = {word, 1}, both truncated to SRAM_ADDR_W bits. Out-of-range addresses wrap silently.
- ready (combinational) = ~(wr_en | rd_en) | (state == DONE).
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: if wr_en or rd_en, latch the operation, word and write_data, then go to LOW. wr_en has priority when both are high; the request is treated as a write and read_data is unchanged.
  - LOW: sram_addr = low half. Stays for WAIT_CYCLES cycles, then goes to HIGH.
  - HIGH: sram_addr = high half. Stays for WAIT_CYCLES cycles, then goes to DONE.
  - DONE: one cycle with ready=1, then back to IDLE.
- Write request:
  - sram_dq_oe=1 in LOW and HIGH.
  - sram_dq_out = write_data[15:0] in LOW and write_data[31:16] in HIGH.
  - sram_we_n=0 in LOW and HIGH except the final cycle of each half, where it is 1 (data hold before the address changes).
- Read request:
  - sram_we_n=1 and sram_dq_oe=0 throughout.
  - sram_dq_in is sampled on the last cycle of LOW into read_data[15:0] and on the last cycle of HIGH into read_data[31:16].
  - read_data is complete in DONE and holds until the next read overwrites it.
- Latency: with the request first seen in cycle 0, ready is low in cycles 0..2·WAIT_CYCLES and high in cycle 2·WAIT_CYCLES+1. That is 6 cycles total for WAIT_CYCLES=2.
- Deasserting wr_en/rd_en mid-transaction does not abort it; the transaction completes.
- Back-to-back requests: a request present in the cycle after DONE starts a new transaction from IDLE, and ready drops again that cycle.

Optional Feature:
SRAM_READ_BYPASS_EN:
- Defined: a one-entry tag/data register holds the last completed read (valid bit and word).
  - A read in IDLE whose word matches a valid entry goes directly to DONE and returns the stored data. ready is low 1 cycle, high the next, and no SRAM access occurs.
  - Any write in IDLE clears the valid bit.
  - Reset clears the valid bit.
- Undefined: every read takes the full SRAM sequence.

Test Plan:
- Write 0x12345678 to address 1024 with WAIT_CYCLES=2 -> sram_addr 0 gets 0x5678, then sram_addr 1 gets 0x1234. sram_we_n is low 1 cycle per half, ready=0 in cycles 0–4 and ready=1 in cycle 5, then IDLE.
- Read address 1024 with the SRAM model holding those values -> read_data=0x12345678 in cycle 5; sram_dq_oe stays 0.
- Write 0xDEADBEEF to address 1032 -> sram_addr 4 gets 0xBEEF and 5 gets 0xDEAD. Reading it back returns 0xDEADBEEF.
- wr_en and rd_en both high, address 1028, data 0xA5A5A5A5 -> performs a write to sram_addr 2/3; read_data is unchanged from its previous value.
- Assert rst in cycle 2 of a write -> immediately state=IDLE, sram_we_n=1, sram_dq_oe=0, read_data=0, ready=~(wr_en|rd_en).
- SRAM_READ_BYPASS_EN defined, read 1024 twice consecutively -> second read shows ready=0 for 1 cycle then 1 with no sram_addr activity. A read after an intervening write to 1024 takes the full 6 cycles.
